// File: rtl/seq_det_arb_ctrl_if.sv
// ============================================================================
// Module   : seq_det_arb_ctrl_if
// Purpose  : Bundles the requester handshake and detector-side signals of the
//            sequence-detector arbiter into one interface.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Signals
//   req      NREQ        per-requester burst request (level)
//   req_len  NREQ*LEN_W  per-requester burst length
//   sym_in   NREQ*DW     per-requester symbol
//   sym_vld  NREQ        per-requester symbol valid
//   sym_rdy  NREQ        per-requester symbol ready
//   gnt      NREQ        one-hot grant
//   done     NREQ        1-cycle burst-complete pulse
//   hit      1           detector output seen during the burst (valid with done)
//   aborted  1           burst ended by request drop (valid with done)
//   det_clr  1           detector synchronous clear
//   det_a    DW          detector symbol input
//   det_z    1           detector output
// Modports
//   master : arbiter/sequencer side
//   slave  : requester and detector side
// ============================================================================
`default_nettype none

interface seq_det_arb_ctrl_if #(
    parameter int NREQ  = 4,
    parameter int DW    = 4,
    parameter int LEN_W = 4
);
    logic [NREQ-1:0]       req;
    logic [NREQ*LEN_W-1:0] req_len;
    logic [NREQ*DW-1:0]    sym_in;
    logic [NREQ-1:0]       sym_vld;
    logic [NREQ-1:0]       sym_rdy;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       done;
    logic                  hit;
    logic                  aborted;
    logic                  det_clr;
    logic [DW-1:0]         det_a;
    logic                  det_z;

    modport master (
        input  req, req_len, sym_in, sym_vld, det_z,
        output sym_rdy, gnt, done, hit, aborted, det_clr, det_a
    );

    modport slave (
        output req, req_len, sym_in, sym_vld, det_z,
        input  sym_rdy, gnt, done, hit, aborted, det_clr, det_a
    );
endinterface

`default_nettype wire

// File: rtl/seq_det_arb_ctrl.sv
// ============================================================================
// Module   : seq_det_arb_ctrl
// Purpose  : Round-robin arbiter/sequencer sharing one sequence-detector among
//            NREQ requesters. The granted requester streams a burst of
//            req_len symbols; the block clears the detector, feeds symbols,
//            drains the detector latency and reports hit/aborted with done.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk    in  clock, rising edge
//   rst_n  in  asynchronous reset, active low
//   bus    seq_det_arb_ctrl_if.master (requester handshake + detector side)
// ============================================================================
`default_nettype none

module seq_det_arb_ctrl #(
    parameter int            NREQ     = 4,
    parameter int            DW       = 4,
    parameter int            LEN_W    = 4,
    parameter logic [DW-1:0] IDLE_SYM = DW'(4'hF)
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    seq_det_arb_ctrl_if.master bus
);

    localparam int PW = $clog2(NREQ);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLR    = 3'd1,
        S_FEED   = 3'd2,
        S_DRAIN  = 3'd3,
        S_REPORT = 3'd4
    } state_t;

    state_t          r_state;
    logic [NREQ-1:0] r_gnt;
    logic [NREQ-1:0] r_rdy;
    logic [NREQ-1:0] r_done;
    logic            r_hit;
    logic            r_aborted;
    logic            r_det_clr;
    logic [PW-1:0]   r_ptr;      // last granted requester; also the active select
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_cnt;
    logic            r_xfer_d;   // a transfer happened in the previous cycle
    logic            r_drain;    // second DRAIN cycle

    logic            w_any;
    logic [PW-1:0]   w_sel;
    logic [NREQ-1:0] w_gnt_nxt;
    logic [LEN_W-1:0] w_len_sel;
    logic            w_xfer;
    logic [DW-1:0]   w_sym;
    logic            w_req_sel;
    logic            w_z_seen;
    logic [LEN_W-1:0] w_cnt_inc;

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        int idx;
        idx   = 0;
        w_sel = r_ptr;
        w_any = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = int'(r_ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!w_any && bus.req[idx]) begin
                w_any = 1'b1;
                w_sel = PW'(idx);
            end
        end
    end

    assign w_gnt_nxt = NREQ'(1) << w_sel;
    assign w_len_sel = bus.req_len[int'(w_sel)*LEN_W +: LEN_W];

    // sym_rdy is only ever set on the granted bit, so the OR is the transfer.
    assign w_xfer    = |(bus.sym_vld & r_rdy);
    assign w_sym     = bus.sym_in[int'(r_ptr)*DW +: DW];
    assign w_req_sel = bus.req[r_ptr];
    assign w_cnt_inc = r_cnt + LEN_W'(1);

    // det_z is only trusted one cycle after a transfer or while draining;
    // anything else is left over from the previous burst or from a gap.
    assign w_z_seen  = bus.det_z && (r_xfer_d || (r_state == S_DRAIN));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_gnt     <= '0;
            r_rdy     <= '0;
            r_done    <= '0;
            r_hit     <= 1'b0;
            r_aborted <= 1'b0;
            r_det_clr <= 1'b0;
            r_ptr     <= PW'(NREQ - 1);
            r_len     <= '0;
            r_cnt     <= '0;
            r_xfer_d  <= 1'b0;
            r_drain   <= 1'b0;
        end else begin
            r_done    <= '0;
            r_det_clr <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_state   <= S_CLR;
                        r_gnt     <= w_gnt_nxt;
                        r_ptr     <= w_sel;
                        r_len     <= w_len_sel;
                        r_cnt     <= '0;
                        r_det_clr <= 1'b1;
                        r_hit     <= 1'b0;
                        r_aborted <= 1'b0;
                        r_xfer_d  <= 1'b0;
                        r_drain   <= 1'b0;
                    end
                end
                S_CLR: begin
                    if (r_len == '0) begin
                        r_state <= S_DRAIN;
                    end else begin
                        r_state <= S_FEED;
                        r_rdy   <= r_gnt;
                    end
                end
                S_FEED: begin
                    r_xfer_d <= w_xfer;
                    if (!w_req_sel) begin
                        r_state   <= S_DRAIN;
                        r_rdy     <= '0;
                        r_aborted <= 1'b1;
                        r_hit     <= 1'b0;
                    end else begin
                        if (w_z_seen) begin
                            r_hit <= 1'b1;
                        end
                        if (w_xfer) begin
                            r_cnt <= w_cnt_inc;
                            if (w_cnt_inc == r_len) begin
                                r_state <= S_DRAIN;
                                r_rdy   <= '0;
                            end
                        end
                    end
                end
                S_DRAIN: begin
                    r_xfer_d <= 1'b0;
                    if (w_z_seen && !r_aborted) begin
                        r_hit <= 1'b1;
                    end
                    if (r_drain) begin
                        r_state <= S_REPORT;
                        r_done  <= r_gnt;
                    end else begin
                        r_drain <= 1'b1;
                    end
                end
                S_REPORT: begin
                    r_state <= S_IDLE;
                    r_gnt   <= '0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt     = r_gnt;
    assign bus.sym_rdy = r_rdy;
    assign bus.done    = r_done;
    assign bus.hit     = r_hit;
    assign bus.aborted = r_aborted;
    assign bus.det_clr = r_det_clr;
    // Symbol passes straight through on a transfer so the detector sees it
    // in the same cycle; every other cycle carries the idle symbol.
    assign bus.det_a   = w_xfer ? w_sym : IDLE_SYM;

endmodule

`default_nettype wire

// File: tb/tb_seq_det_arb_ctrl.sv
// ============================================================================
// Module   : tb_seq_det_arb_ctrl
// Purpose  : Self-checking bench for seq_det_arb_ctrl with a behavioural
//            detector (fires on consecutive symbols 1,2,3) and a reference
//            model for arbitration order, latency and hit/aborted.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_det_arb_ctrl;
    localparam int            NREQ  = 4;
    localparam int            DW    = 4;
    localparam int            LEN_W = 4;
    localparam logic [DW-1:0] IDLE  = 4'hF;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seq_det_arb_ctrl_if #(.NREQ(NREQ), .DW(DW), .LEN_W(LEN_W)) bus ();

    seq_det_arb_ctrl #(.NREQ(NREQ), .DW(DW), .LEN_W(LEN_W), .IDLE_SYM(IDLE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Behavioural detector: z registered, high after seeing 1,2,3 in a row.
    logic [DW-1:0] d_h1, d_h2;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_h1 <= IDLE; d_h2 <= IDLE; bus.det_z <= 1'b0;
        end else if (bus.det_clr) begin
            d_h1 <= IDLE; d_h2 <= IDLE; bus.det_z <= 1'b0;
        end else begin
            bus.det_z <= (d_h2 == 4'd1) && (d_h1 == 4'd2) && (bus.det_a == 4'd3);
            d_h2 <= d_h1;
            d_h1 <= bus.det_a;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] syms [16];
    int            prio [$];   // priority order, highest first

    logic [NREQ-1:0] obs_gnt, obs_done;
    logic            obs_clr0, obs_clr1, obs_hit, obs_ab;
    int              obs_lat, obs_deta_err;

    task automatic tick();
        @(posedge clk); #1;
    endtask

    function automatic int rr_pick(input logic [NREQ-1:0] m);
        foreach (prio[i]) if (m[prio[i]]) return prio[i];
        return -1;
    endfunction

    // Served requester moves to lowest priority; the rest keep circular order.
    function automatic void rr_served(input int s);
        int x;
        while (prio[$] != s) begin
            x = prio.pop_front();
            prio.push_back(x);
        end
    endfunction

    function automatic void rr_reset();
        prio.delete();
        for (int i = 0; i < NREQ; i++) prio.push_back(i);
    endfunction

    function automatic logic [NREQ-1:0] onehot(input int w);
        logic [NREQ-1:0] v;
        v = '0;
        v[w] = 1'b1;
        return v;
    endfunction

    function automatic bit is_abort(input int len, input int abort_at);
        return (abort_at >= 0) && (abort_at < len);
    endfunction

    function automatic int gap_cycles(input int len, input int gap_at, input int gap_len, input int abort_at);
        int endk;
        endk = is_abort(len, abort_at) ? abort_at : len;
        return (gap_at >= 0 && gap_at < endk) ? gap_len : 0;
    endfunction

    function automatic int model_lat(input int len, input int gap_at, input int gap_len, input int abort_at);
        int g;
        g = gap_cycles(len, gap_at, gap_len, abort_at);
        if (is_abort(len, abort_at)) return 4 + abort_at + g;
        return 3 + len + g;
    endfunction

    // Symbol stream seen by the detector, searched for the 1,2,3 window.
    function automatic bit model_hit(input int len, input int gap_at, input int gap_len, input int abort_at);
        logic [DW-1:0] s [$];
        if (is_abort(len, abort_at)) return 1'b0;
        for (int k = 0; k < len; k++) begin
            if (k == gap_at) for (int g = 0; g < gap_len; g++) s.push_back(IDLE);
            s.push_back(syms[k]);
        end
        for (int i = 0; i + 2 < s.size(); i++)
            if (s[i] == 4'd1 && s[i+1] == 4'd2 && s[i+2] == 4'd3) return 1'b1;
        return 1'b0;
    endfunction

    // Drives one burst for requester r (others in mask also request) and
    // records what the DUT did; leaves the DUT in IDLE on return.
    task automatic drive_burst(input logic [NREQ-1:0] mask, input int r, input int len,
                               input int gap_at, input int gap_len, input int abort_at);
        int k, gleft;
        bit xf, fin, ab;
        logic [DW-1:0] exp_a;
        for (int j = 0; j < NREQ; j++) bus.req_len[j*LEN_W +: LEN_W] = LEN_W'($urandom_range(0, 15));
        bus.req_len[r*LEN_W +: LEN_W] = LEN_W'(len);
        bus.req = mask;
        tick();
        obs_gnt = bus.gnt; obs_clr0 = bus.det_clr; obs_clr1 = 1'b0;
        obs_done = '0; obs_hit = 1'b0; obs_ab = 1'b0;
        obs_lat = 0; obs_deta_err = 0;
        k = 0; gleft = gap_len; fin = 1'b0; ab = 1'b0;
        while (!fin) begin
            for (int j = 0; j < NREQ; j++) begin
                bus.sym_in[j*DW +: DW] = DW'($urandom);
                bus.sym_vld[j] = (j != r) ? 1'($urandom) : 1'b0;
            end
            xf = 1'b0;
            if (bus.sym_rdy[r] && !ab) begin
                if (k == abort_at) begin
                    bus.req[r] = 1'b0; ab = 1'b1;
                end else if (k == gap_at && gleft > 0) begin
                    gleft--;
                end else if (k < len) begin
                    bus.sym_vld[r] = 1'b1;
                    bus.sym_in[r*DW +: DW] = syms[k];
                    xf = 1'b1;
                end
            end
            #1;
            exp_a = xf ? syms[k] : IDLE;
            if (bus.det_a !== exp_a) obs_deta_err++;
            tick();
            if (xf) k++;
            obs_lat++;
            if (obs_lat == 1) obs_clr1 = bus.det_clr;
            if (bus.done != '0) begin
                fin = 1'b1; obs_done = bus.done; obs_hit = bus.hit; obs_ab = bus.aborted;
            end else if (obs_lat > 60) begin
                fin = 1'b1;
            end
        end
        bus.req = '0; bus.sym_vld = '0;
        tick();
    endtask

    task automatic test_reset();
        n_tests++; if (bus.gnt !== '0) begin n_fail++; $display("FAIL reset_gnt: got %b want 0", bus.gnt); end
        n_tests++; if (bus.sym_rdy !== '0) begin n_fail++; $display("FAIL reset_rdy: got %b want 0", bus.sym_rdy); end
        n_tests++; if (bus.done !== '0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.done); end
        n_tests++; if ({bus.hit, bus.aborted, bus.det_clr} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got hit/ab/clr %b want 000", {bus.hit, bus.aborted, bus.det_clr}); end
        n_tests++; if (bus.det_a !== IDLE) begin n_fail++; $display("FAIL reset_det_a: got %h want F", bus.det_a); end
    endtask

    task automatic test_round_robin();
        int w, cyc;
        logic [NREQ-1:0] all;
        all = '1;
        bus.req = all;
        for (int j = 0; j < NREQ; j++) bus.req_len[j*LEN_W +: LEN_W] = LEN_W'(1);
        bus.sym_in = '0; bus.sym_vld = '1;
        for (int g = 0; g < 5; g++) begin
            cyc = 0;
            while (bus.gnt == '0 && cyc < 20) begin tick(); cyc++; end
            w = rr_pick(all);
            n_tests++; if (bus.gnt !== onehot(w)) begin n_fail++; $display("FAIL rr_gnt%0d: got %b want %b", g, bus.gnt, onehot(w)); end
            rr_served(w);
            cyc = 0;
            while (bus.done == '0 && cyc < 20) begin tick(); cyc++; end
            n_tests++; if (bus.done !== onehot(w)) begin n_fail++; $display("FAIL rr_done%0d: got %b want %b", g, bus.done, onehot(w)); end
            if (g == 4) begin bus.req = '0; bus.sym_vld = '0; end
            tick();
        end
        tick();
    endtask

    task automatic test_basic();
        for (int i = 0; i < 5; i++) syms[i] = DW'(i);
        drive_burst(4'b0001, 0, 5, -1, 0, -1);
        rr_served(0);
        n_tests++; if (obs_gnt !== 4'b0001) begin n_fail++; $display("FAIL basic_gnt: got %b want 0001", obs_gnt); end
        n_tests++; if ({obs_clr0, obs_clr1} !== 2'b10) begin n_fail++; $display("FAIL basic_clr: got %b want 10", {obs_clr0, obs_clr1}); end
        n_tests++; if (obs_lat != 8) begin n_fail++; $display("FAIL basic_lat: got %0d want 8", obs_lat); end
        n_tests++; if (obs_done !== 4'b0001) begin n_fail++; $display("FAIL basic_done: got %b want 0001", obs_done); end
        n_tests++; if ({obs_hit, obs_ab} !== 2'b10) begin n_fail++; $display("FAIL basic_hit_ab: got %b want 10", {obs_hit, obs_ab}); end
        n_tests++; if (obs_deta_err != 0) begin n_fail++; $display("FAIL basic_det_a: got %0d bad cycles want 0", obs_deta_err); end
    endtask

    task automatic test_mismatch();
        syms[0] = 4'd0; syms[1] = 4'd1; syms[2] = 4'd9; syms[3] = 4'd3; syms[4] = 4'd4;
        drive_burst(4'b0001, 0, 5, -1, 0, -1);
        rr_served(0);
        n_tests++; if (obs_done !== 4'b0001) begin n_fail++; $display("FAIL mis_done: got %b want 0001", obs_done); end
        n_tests++; if ({obs_hit, obs_ab} !== 2'b00) begin n_fail++; $display("FAIL mis_hit_ab: got %b want 00", {obs_hit, obs_ab}); end
    endtask

    task automatic test_gap();
        for (int i = 0; i < 5; i++) syms[i] = DW'(i);
        drive_burst(4'b0100, 2, 5, 2, 2, -1);
        rr_served(2);
        n_tests++; if (obs_gnt !== 4'b0100) begin n_fail++; $display("FAIL gap_gnt: got %b want 0100", obs_gnt); end
        n_tests++; if (obs_lat != 10) begin n_fail++; $display("FAIL gap_lat: got %0d want 10", obs_lat); end
        n_tests++; if (obs_hit !== 1'b0) begin n_fail++; $display("FAIL gap_hit: got %b want 0", obs_hit); end
        n_tests++; if (obs_deta_err != 0) begin n_fail++; $display("FAIL gap_det_a: got %0d bad cycles want 0", obs_deta_err); end
        drive_burst(4'b0100, 2, 5, -1, 0, -1);
        rr_served(2);
        n_tests++; if (obs_hit !== 1'b1) begin n_fail++; $display("FAIL nogap_hit: got %b want 1", obs_hit); end
    endtask

    task automatic test_abort();
        for (int i = 0; i < 6; i++) syms[i] = DW'(i + 1);
        drive_burst(4'b0010, 1, 6, -1, 0, 3);
        rr_served(1);
        n_tests++; if (obs_done !== 4'b0010) begin n_fail++; $display("FAIL abort_done: got %b want 0010", obs_done); end
        n_tests++; if (obs_lat != 7) begin n_fail++; $display("FAIL abort_lat: got %0d want 7", obs_lat); end
        n_tests++; if ({obs_hit, obs_ab} !== 2'b01) begin n_fail++; $display("FAIL abort_hit_ab: got %b want 01", {obs_hit, obs_ab}); end
        drive_burst(4'b0010, 1, 0, -1, 0, -1);
        rr_served(1);
        n_tests++; if (obs_lat != 3) begin n_fail++; $display("FAIL len0_lat: got %0d want 3", obs_lat); end
        n_tests++; if ({obs_done, obs_hit, obs_ab} !== {4'b0010, 2'b00}) begin n_fail++; $display("FAIL len0_result: got %b want 001000", {obs_done, obs_hit, obs_ab}); end
    endtask

    task automatic test_back_to_back_random();
        logic [NREQ-1:0] mask;
        int r, len, gap_at, gap_len, abort_at;
        for (int it = 0; it < 25; it++) begin
            mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            r    = rr_pick(mask);
            len  = $urandom_range(0, 8);
            for (int i = 0; i < 16; i++) syms[i] = DW'($urandom_range(0, 4));
            gap_at   = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 8) : -1;
            gap_len  = $urandom_range(1, 3);
            abort_at = (len > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : -1;
            drive_burst(mask, r, len, gap_at, gap_len, abort_at);
            rr_served(r);
            n_tests++; if (obs_gnt !== onehot(r)) begin n_fail++; $display("FAIL rnd%0d_gnt: got %b want %b", it, obs_gnt, onehot(r)); end
            n_tests++; if (obs_done !== onehot(r)) begin n_fail++; $display("FAIL rnd%0d_done: got %b want %b", it, obs_done, onehot(r)); end
            n_tests++; if (obs_lat != model_lat(len, gap_at, gap_len, abort_at)) begin n_fail++; $display("FAIL rnd%0d_lat: got %0d want %0d", it, obs_lat, model_lat(len, gap_at, gap_len, abort_at)); end
            n_tests++; if (obs_hit !== model_hit(len, gap_at, gap_len, abort_at)) begin n_fail++; $display("FAIL rnd%0d_hit: got %b want %b", it, obs_hit, model_hit(len, gap_at, gap_len, abort_at)); end
            n_tests++; if (obs_ab !== is_abort(len, abort_at)) begin n_fail++; $display("FAIL rnd%0d_aborted: got %b want %b", it, obs_ab, is_abort(len, abort_at)); end
            n_tests++; if (obs_deta_err != 0) begin n_fail++; $display("FAIL rnd%0d_det_a: got %0d bad cycles want 0", it, obs_deta_err); end
        end
    endtask

    task automatic test_reset_mid();
        bus.req_len = '0;
        bus.req_len[LEN_W-1:0] = LEN_W'(5);
        bus.req = 4'b0001;
        tick(); tick();
        bus.sym_vld[0] = 1'b1; bus.sym_in[DW-1:0] = 4'd1;
        tick(); tick();
        rst_n = 1'b0;
        #2;
        n_tests++; if ({bus.gnt, bus.sym_rdy, bus.done} !== '0) begin n_fail++; $display("FAIL midrst_vec: got gnt/rdy/done %b want 0", {bus.gnt, bus.sym_rdy, bus.done}); end
        n_tests++; if ({bus.hit, bus.aborted, bus.det_clr} !== 3'b000) begin n_fail++; $display("FAIL midrst_flags: got %b want 000", {bus.hit, bus.aborted, bus.det_clr}); end
        n_tests++; if (bus.det_a !== IDLE) begin n_fail++; $display("FAIL midrst_det_a: got %h want F", bus.det_a); end
        bus.req = '0; bus.sym_vld = '0;
        @(negedge clk);
        rst_n = 1'b1;
        rr_reset();
        tick();
        for (int i = 0; i < 3; i++) syms[i] = DW'(i + 1);
        drive_burst(4'b0001, 0, 3, -1, 0, -1);
        rr_served(0);
        n_tests++; if (obs_gnt !== 4'b0001) begin n_fail++; $display("FAIL postrst_gnt: got %b want 0001", obs_gnt); end
        n_tests++; if (obs_lat != 6) begin n_fail++; $display("FAIL postrst_lat: got %0d want 6", obs_lat); end
        n_tests++; if ({obs_done, obs_hit, obs_ab} !== {4'b0001, 2'b10}) begin n_fail++; $display("FAIL postrst_result: got %b want 000110", {obs_done, obs_hit, obs_ab}); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.req = '0; bus.req_len = '0; bus.sym_in = '0; bus.sym_vld = '0;
        rr_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        test_reset();
        test_round_robin();
        test_basic();
        test_mismatch();
        test_gap();
        test_abort();
        test_back_to_back_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
